// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  // Edges between the RAM sampling its address and q being usable.
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes a raw key level, debounces it and emits a one-cycle pulse
// on each rising edge of the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic key_raw,
  output logic key_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Down-counter runs only while the synchronized level disagrees with the
  // debounced level; any agreement reloads it, so the flip needs an unbroken run.
  always_comb begin
    sync_d      = {sync_q[0], key_raw};
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = CNT_LOAD;
    if (sync_q[1] != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= CNT_LOAD;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
    end
  end

  assign key_rise = level_q & ~level_dly_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer in front of the 32x8 single-port RAM: debounced write strobes,
// latency-aware reads with read-back after every write, optional auto-scan.
//
// state  | meaning
// IDLE   | choose next transaction: pending write first, then a due read
// WRITE  | ram_wren high for this single cycle
// ISSUE  | address held while the RAM registers it
// WAIT   | q valid; capture into disp_*, advance scan pointer if scan read
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              wr_req,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int LAT_W = 2;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RAM_RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              disp_valid_q, disp_valid_d;
  logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              scan_tick_q, scan_tick_d;
  logic              wr_pend_q, wr_pend_d;
  logic              scan_rd_q, scan_rd_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              wr_rise;
  logic              wr_take;
  logic              tick_take;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_wr_debounce (
    .clk_sys  (CLOCK_50),
    .rst      (reset),
    .key_raw  (wr_req),
    .key_rise (wr_rise)
  );

  // Sticky write request; a rise while one is already pending is dropped.
  always_comb begin
    wr_pend_d = wr_pend_q;
    if (wr_take) begin
      wr_pend_d = 1'b0;
    end else if (wr_rise) begin
      wr_pend_d = 1'b1;
    end
  end

  // Scan divider and sticky tick; a new tick wins over consumption of the old one.
  always_comb begin
    div_d       = '0;
    scan_tick_d = 1'b0;
    if (scan_en) begin
      scan_tick_d = scan_tick_q & ~tick_take;
      if (div_q == DIV_LAST) begin
        div_d       = '0;
        scan_tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Transaction FSM: next state, RAM pins and display capture.
  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    scan_ptr_d   = scan_ptr_q;
    scan_rd_d    = scan_rd_q;
    lat_d        = lat_q;
    wr_take      = 1'b0;
    tick_take    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_pend_q) begin
          state_d    = ST_WRITE;
          ram_addr_d = sw_addr;
          ram_data_d = sw_data;
          ram_wren_d = 1'b1;
          scan_rd_d  = 1'b0;
          wr_take    = 1'b1;
        end else if (scan_en) begin
          if (scan_tick_q) begin
            state_d    = ST_ISSUE;
            ram_addr_d = scan_ptr_q;
            scan_rd_d  = 1'b1;
          end
        end else begin
          state_d    = ST_ISSUE;
          ram_addr_d = sw_addr;
          scan_rd_d  = 1'b0;
        end
      end

      // Read-back of the address just written.
      ST_WRITE: begin
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = LAT_LOAD;
      end

      ST_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          disp_addr_d  = ram_addr_q;
          disp_data_d  = ram_q;
          disp_valid_d = 1'b1;
          if (scan_rd_q) begin
            scan_ptr_d = scan_ptr_q + 1'b1;
            tick_take  = 1'b1;
          end
          scan_rd_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All controller state; reset drops ram_wren and forgets pending work at once.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      scan_ptr_q   <= '0;
      div_q        <= '0;
      scan_tick_q  <= 1'b0;
      wr_pend_q    <= 1'b0;
      scan_rd_q    <= 1'b0;
      lat_q        <= '0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      scan_ptr_q   <= scan_ptr_d;
      div_q        <= div_d;
      scan_tick_q  <= scan_tick_d;
      wr_pend_q    <= wr_pend_d;
      scan_rd_q    <= scan_rd_d;
      lat_q        <= lat_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign ram_wren   = ram_wren_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule
